// File: rtl/frame_bus_arbiter.sv
// frame_bus_arbiter: round-robin arbiter of NUM_CH frame FIFO channels onto a
// single burst memory port. Writers drain their FIFO into memory and readers
// refill theirs from memory. Each channel walks its own frame region, and only
// one burst is in flight at a time.

// Per-channel view: next burst length, eligibility and burst start address.
module frame_bus_arbiter_lane #(
    parameter int          CH_IDX       = 0,
    parameter bit          IS_READ      = 1'b0,
    parameter int          ADDR_W       = 24,
    parameter int          USEDW_W      = 9,
    parameter int          OFF_W        = 17,
    parameter int          FIFO_DEPTH   = 512,
    parameter int          BURST_LEN    = 64,
    parameter int          FRAME_WORDS  = 76800,
    parameter int          FRAME_STRIDE = 131072
) (
    input  logic               enable,
    input  logic               done,
    input  logic [USEDW_W-1:0] usedw,
    input  logic [OFF_W-1:0]   offset,
    output logic [7:0]         len,
    output logic               eligible,
    output logic [ADDR_W-1:0]  addr
);
    logic [31:0] remain;
    logic [31:0] avail;

    // Burst is the lesser of BURST_LEN and what is left of the frame; a
    // writer needs that many words queued, a reader that much free space.
    always_comb begin
        remain   = 32'(FRAME_WORDS) - 32'(offset);
        len      = (remain >= 32'(BURST_LEN)) ? 8'(BURST_LEN) : remain[7:0];
        avail    = IS_READ ? (32'(FIFO_DEPTH) - 32'(usedw)) : 32'(usedw);
        eligible = enable & ~done & (len != 8'd0) & (avail >= 32'(len));
        addr     = ADDR_W'(CH_IDX * FRAME_STRIDE) + ADDR_W'(offset);
    end
endmodule

module frame_bus_arbiter #(
    parameter int                 NUM_CH       = 2,
    parameter logic [NUM_CH-1:0]  CH_IS_READ   = 2'b10,
    parameter int                 DATA_W       = 32,
    parameter int                 ADDR_W       = 24,
    parameter int                 USEDW_W      = 9,
    parameter int                 FIFO_DEPTH   = 512,
    parameter int                 BURST_LEN    = 64,
    parameter int                 FRAME_WORDS  = 76800,
    parameter int                 FRAME_STRIDE = 131072
) (
    input  logic                        ctrl_clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic [NUM_CH-1:0]           ch_enable,
    input  logic [NUM_CH*USEDW_W-1:0]   fifo_usedw,
    input  logic [NUM_CH*DATA_W-1:0]    fifo_q,
    output logic [NUM_CH-1:0]           fifo_pop,
    output logic [NUM_CH-1:0]           fifo_push,
    output logic [DATA_W-1:0]           fifo_d,
    output logic                        mem_cmd_valid,
    input  logic                        mem_cmd_ready,
    output logic                        mem_cmd_write,
    output logic [ADDR_W-1:0]           mem_cmd_addr,
    output logic [7:0]                  mem_cmd_len,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_wready,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_rvalid,
    output logic [NUM_CH-1:0]           frame_done,
    output logic                        busy
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OFF_W = $clog2(FRAME_WORDS + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_CMD, S_WDATA, S_RDATA} state_t;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
    } burst_t;

    state_t                          state, state_nxt;
    burst_t                          cur;
    logic [CH_W-1:0]                 rr_ptr;
    logic [7:0]                      beat_cnt;
    logic [NUM_CH-1:0][OFF_W-1:0]    offsets;
    logic [NUM_CH-1:0]               done;
    logic                            rewind_pend;

    logic [NUM_CH-1:0][USEDW_W-1:0]  usedw_a;
    logic [NUM_CH-1:0][DATA_W-1:0]   fifo_q_a;
    logic [NUM_CH-1:0][7:0]          lane_len;
    logic [NUM_CH-1:0][ADDR_W-1:0]   lane_addr;
    logic [NUM_CH-1:0]               lane_elig;

    logic                            arb_found;
    logic [CH_W-1:0]                 arb_idx;
    logic [CH_W-1:0]                 rr_next;
    logic                            beat_fire;
    logic                            last_beat;
    logic [OFF_W-1:0]                off_sum;

    assign usedw_a  = fifo_usedw;
    assign fifo_q_a = fifo_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        frame_bus_arbiter_lane #(
            .CH_IDX       (i),
            .IS_READ      (CH_IS_READ[i]),
            .ADDR_W       (ADDR_W),
            .USEDW_W      (USEDW_W),
            .OFF_W        (OFF_W),
            .FIFO_DEPTH   (FIFO_DEPTH),
            .BURST_LEN    (BURST_LEN),
            .FRAME_WORDS  (FRAME_WORDS),
            .FRAME_STRIDE (FRAME_STRIDE)
        ) u_lane (
            .enable   (ch_enable[i]),
            .done     (done[i]),
            .usedw    (usedw_a[i]),
            .offset   (offsets[i]),
            .len      (lane_len[i]),
            .eligible (lane_elig[i]),
            .addr     (lane_addr[i])
        );
    end

    // Round-robin pick: first eligible channel at or after rr_ptr. The scan
    // runs from farthest to nearest so the nearest match is the one kept.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (lane_elig[(int'(rr_ptr) + k) % NUM_CH]) begin
                arb_found = 1'b1;
                arb_idx   = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            end
        end
        rr_next = CH_W'((int'(arb_idx) + 1) % NUM_CH);
    end

    // Beat bookkeeping shared by the write and read data phases.
    always_comb begin
        beat_fire = ((state == S_WDATA) && mem_wready) ||
                    ((state == S_RDATA) && mem_rvalid);
        last_beat = beat_fire && (beat_cnt == (cur.len - 8'd1));
        off_sum   = offsets[cur.ch] + OFF_W'(cur.len);
    end

    // State register.
    always_ff @(posedge ctrl_clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and port outputs; a finished burst goes straight back to ARB.
    always_comb begin
        state_nxt     = state;
        mem_cmd_valid = 1'b0;
        mem_cmd_write = cur.write;
        mem_cmd_addr  = cur.addr;
        mem_cmd_len   = cur.len;
        mem_wdata     = '0;
        fifo_d        = '0;
        fifo_pop      = '0;
        fifo_push     = '0;
        busy          = (state != S_IDLE);
        case (state)
            S_IDLE:  if (|lane_elig) state_nxt = S_ARB;
            S_ARB:   state_nxt = arb_found ? S_CMD : S_IDLE;
            S_CMD: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) state_nxt = cur.write ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                mem_wdata = fifo_q_a[cur.ch];
                fifo_pop[cur.ch] = mem_wready;
                if (last_beat) state_nxt = S_ARB;
            end
            S_RDATA: begin
                fifo_d = mem_rdata;
                fifo_push[cur.ch] = mem_rvalid;
                if (last_beat) state_nxt = S_ARB;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant latch: command fields are frozen at ARB so they stay stable in CMD.
    always_ff @(posedge ctrl_clk or posedge reset) begin
        if (reset) begin
            cur      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if ((state == S_ARB) && arb_found) begin
                cur.ch    <= arb_idx;
                cur.write <= ~CH_IS_READ[arb_idx];
                cur.addr  <= lane_addr[arb_idx];
                cur.len   <= lane_len[arb_idx];
                rr_ptr    <= rr_next;
                beat_cnt  <= '0;
            end else if (beat_fire) begin
                beat_cnt  <= beat_cnt + 8'd1;
            end
        end
    end

    // Frame progress. A rewind that lands while a burst is committed is held
    // until that burst ends, so the burst finishes at its old address and the
    // channel neither completes its frame nor pulses frame_done.
    always_ff @(posedge ctrl_clk or posedge reset) begin
        if (reset) begin
            offsets     <= '0;
            done        <= '0;
            frame_done  <= '0;
            rewind_pend <= 1'b0;
        end else begin
            frame_done <= '0;
            if (frame_start && ((state == S_IDLE) || (state == S_ARB))) begin
                offsets <= '0;
                done    <= '0;
            end
            if (last_beat) begin
                rewind_pend <= 1'b0;
                if (rewind_pend || frame_start) begin
                    offsets <= '0;
                    done    <= '0;
                end else begin
                    offsets[cur.ch] <= off_sum;
                    if (off_sum == OFF_W'(FRAME_WORDS)) begin
                        done[cur.ch]       <= 1'b1;
                        frame_done[cur.ch] <= 1'b1;
                    end
                end
            end else if (frame_start &&
                         ((state == S_CMD) || (state == S_WDATA) ||
                          (state == S_RDATA) || ((state == S_ARB) && arb_found))) begin
                rewind_pend <= 1'b1;
            end
        end
    end
endmodule
